// File: rtl/leaf_out_packetizer.sv
// Output-side BFT leaf packetizer: buffers user words in a small FIFO and issues
// addressed packets while credits for the receiver's input buffer remain.
module leaf_out_packetizer #(
  parameter int unsigned PACKET_BITS     = 49,
  parameter int unsigned PAYLOAD_BITS    = 32,
  parameter int unsigned NUM_LEAF_BITS   = 5,
  parameter int unsigned NUM_PORT_BITS   = 4,
  parameter int unsigned NUM_ADDR_BITS   = 7,
  parameter int unsigned FIFO_DEPTH_BITS = 4
) (
  input  logic                     clk_bft,
  input  logic                     reset_bft,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic [PAYLOAD_BITS-1:0]  din,
  input  logic                     din_vld,
  output logic                     din_ack,
  output logic [PACKET_BITS-1:0]   pkt_out,
  input  logic                     pkt_out_ready,
  input  logic                     credit_vld,
  input  logic [NUM_ADDR_BITS:0]   credit_cnt,
  output logic [NUM_ADDR_BITS:0]   credits,
  output logic                     credit_err
);

  localparam int unsigned FIFO_DEPTH  = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned MAX_CREDITS = 1 << NUM_ADDR_BITS;

  logic [PAYLOAD_BITS-1:0]    mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
  logic [PACKET_BITS-1:0]     pkt_q, pkt_d;
  logic [NUM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [NUM_ADDR_BITS:0]     credits_q, credits_d;
  logic                       err_q, err_d;
  logic [NUM_ADDR_BITS+1:0]   credit_sum;

  logic fifo_full, fifo_empty, push, issue, pkt_valid;

  assign fifo_full  = (count_q == (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pkt_valid  = pkt_q[PACKET_BITS-1];
  assign din_ack    = !fifo_full && !reset_bft;
  assign push       = din_vld && din_ack;
  assign issue      = !fifo_empty && (credits_q != '0) && (!pkt_valid || pkt_out_ready);

  assign pkt_out    = pkt_q;
  assign credits    = credits_q;
  assign credit_err = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pkt_d    = pkt_q;
    addr_d   = addr_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    count_d = count_q + (FIFO_DEPTH_BITS+1)'(push) - (FIFO_DEPTH_BITS+1)'(issue);

    if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      pkt_d    = {1'b1, cfg_dest_leaf, cfg_dest_port, addr_q, mem_q[rd_ptr_q]};
      addr_d   = addr_q + 1'b1;
    end else if (pkt_valid && pkt_out_ready) begin
      pkt_d = '0;
    end

    // Issue only happens with credits_q != 0, so the subtraction cannot underflow.
    credit_sum = {1'b0, credits_q} - (NUM_ADDR_BITS+2)'(issue)
               + (credit_vld ? {1'b0, credit_cnt} : '0);
    if (credit_sum > (NUM_ADDR_BITS+2)'(MAX_CREDITS)) begin
      credits_d = (NUM_ADDR_BITS+1)'(MAX_CREDITS);
      err_d     = 1'b1;
    end else begin
      credits_d = credit_sum[NUM_ADDR_BITS:0];
    end
  end

  always_ff @(posedge clk_bft) begin
    if (reset_bft) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_q     <= '0;
      addr_q    <= '0;
      credits_q <= (NUM_ADDR_BITS+1)'(MAX_CREDITS);
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_q     <= pkt_d;
      addr_q    <= addr_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk_bft) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Directed bench for leaf_out_packetizer: table-driven basic flow plus
// hand-written backpressure, credit, overflow and reset sequences.
module tb_leaf_out_packetizer;

  logic        clk_bft = 1'b0;
  logic        reset_bft;
  logic [4:0]  cfg_dest_leaf;
  logic [3:0]  cfg_dest_port;
  logic [31:0] din;
  logic        din_vld;
  logic        din_ack;
  logic [48:0] pkt_out;
  logic        pkt_out_ready;
  logic        credit_vld;
  logic [7:0]  credit_cnt;
  logic [7:0]  credits;
  logic        credit_err;

  int checks = 0;
  int errors = 0;

  leaf_out_packetizer #(
    .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5),
    .NUM_PORT_BITS(4), .NUM_ADDR_BITS(7), .FIFO_DEPTH_BITS(4)
  ) dut (
    .clk_bft(clk_bft), .reset_bft(reset_bft),
    .cfg_dest_leaf(cfg_dest_leaf), .cfg_dest_port(cfg_dest_port),
    .din(din), .din_vld(din_vld), .din_ack(din_ack),
    .pkt_out(pkt_out), .pkt_out_ready(pkt_out_ready),
    .credit_vld(credit_vld), .credit_cnt(credit_cnt),
    .credits(credits), .credit_err(credit_err)
  );

  always #5 clk_bft = ~clk_bft;

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        exp_ack;
    logic [48:0] exp_pkt;
    logic [7:0]  exp_cr;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [48:0] mk(input logic [6:0] addr, input logic [31:0] pay);
    return {1'b1, 5'd3, 4'd2, addr, pay};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_bft);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_bft);
  endtask

  task automatic do_reset();
    reset_bft  = 1'b1;
    din_vld    = 1'b0;
    credit_vld = 1'b0;
    repeat (2) next_cycle();
    mid();
    chk("rst_ack", {63'd0, din_ack}, 64'd0);
    chk("rst_pkt", {15'd0, pkt_out}, 64'd0);
    chk("rst_credits", {56'd0, credits}, 64'd128);
    chk("rst_err", {63'd0, credit_err}, 64'd0);
    next_cycle();
    reset_bft = 1'b0;
  endtask

  initial begin
    int acc, n, sent, bad, stale;
    logic [48:0] got [$];
    logic [48:0] held;

    tbl[0] = '{1'b1, 32'hA0, 1'b1, 49'd0,          8'd128};
    tbl[1] = '{1'b1, 32'hA1, 1'b1, 49'd0,          8'd128};
    tbl[2] = '{1'b1, 32'hA2, 1'b1, mk(7'd0, 32'hA0), 8'd127};
    tbl[3] = '{1'b1, 32'hA3, 1'b1, mk(7'd1, 32'hA1), 8'd126};
    tbl[4] = '{1'b0, 32'h0,  1'b1, mk(7'd2, 32'hA2), 8'd125};
    tbl[5] = '{1'b0, 32'h0,  1'b1, mk(7'd3, 32'hA3), 8'd124};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 49'd0,          8'd124};

    cfg_dest_leaf = 5'd3;
    cfg_dest_port = 4'd2;
    din           = '0;
    pkt_out_ready = 1'b1;
    credit_cnt    = '0;
    do_reset();

    // Basic flow: latency c+2, ordering, addressing, credit consumption.
    for (int i = 0; i < 7; i++) begin
      din_vld = tbl[i].vld;
      din     = tbl[i].data;
      mid();
      chk($sformatf("t%0d_ack", i), {63'd0, din_ack}, {63'd0, tbl[i].exp_ack});
      chk($sformatf("t%0d_pkt", i), {15'd0, pkt_out}, {15'd0, tbl[i].exp_pkt});
      chk($sformatf("t%0d_cr", i), {56'd0, credits}, {56'd0, tbl[i].exp_cr});
      next_cycle();
    end

    // Backpressure: 16 in FIFO plus 1 held in the output register.
    pkt_out_ready = 1'b0;
    acc = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      din_vld = 1'b1;
      din     = 32'hB00 + acc;
      mid();
      if (i >= 2 && pkt_out !== mk(7'd4, 32'hB00)) bad++;
      if (din_ack) acc++;
      next_cycle();
    end
    din_vld = 1'b0;
    mid();
    chk("bp_accepted", 64'(acc), 64'd17);
    chk("bp_ack_low", {63'd0, din_ack}, 64'd0);
    chk("bp_pkt_stable", 64'(bad), 64'd0);
    chk("bp_pkt_held", {15'd0, pkt_out}, {15'd0, mk(7'd4, 32'hB00)});
    next_cycle();
    pkt_out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 40; i++) begin
      mid();
      if (i == 0) chk("bp_ack_full", {63'd0, din_ack}, 64'd0);
      if (i == 1) chk("bp_ack_back", {63'd0, din_ack}, 64'd1);
      if (pkt_out[48]) got.push_back(pkt_out);
      next_cycle();
    end
    chk("bp_drain_count", 64'(got.size()), 64'd17);
    bad = 0;
    foreach (got[k]) if (got[k] !== mk(7'(4 + k), 32'hB00 + k)) bad++;
    chk("bp_drain_order", 64'(bad), 64'd0);
    mid();
    chk("bp_credits", {56'd0, credits}, 64'd107);
    next_cycle();

    // Credit exhaustion: 130 words, only 128 may issue until credits return.
    do_reset();
    sent = 0;
    n = 0;
    bad = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      din_vld = (sent < 130);
      din     = 32'hC000 + sent;
      mid();
      if (din_vld && din_ack) sent++;
      if (pkt_out[48]) begin
        if (pkt_out !== mk(7'(n), 32'hC000 + n)) bad++;
        n++;
      end
      next_cycle();
    end
    din_vld = 1'b0;
    mid();
    chk("ex_sent", 64'(sent), 64'd130);
    chk("ex_issued", 64'(n), 64'd128);
    chk("ex_credits0", {56'd0, credits}, 64'd0);
    chk("ex_pkt_idle", {63'd0, pkt_out[48]}, 64'd0);
    next_cycle();
    credit_vld = 1'b1;
    credit_cnt = 8'd64;
    next_cycle();
    credit_vld = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      mid();
      if (pkt_out[48]) begin
        if (pkt_out !== mk(7'(n), 32'hC000 + n)) bad++;
        n++;
      end
      next_cycle();
    end
    mid();
    chk("ex_issued_all", 64'(n), 64'd130);
    chk("ex_order_wrap", 64'(bad), 64'd0);
    chk("ex_credits62", {56'd0, credits}, 64'd62);
    next_cycle();

    // Bring credits to 1, then issue and return one credit in the same cycle.
    sent = 0;
    for (int cyc = 0; cyc < 100 && sent < 61; cyc++) begin
      din_vld = 1'b1;
      din     = 32'hE00 + sent;
      mid();
      if (din_ack) sent++;
      next_cycle();
    end
    din_vld = 1'b0;
    repeat (5) next_cycle();
    mid();
    chk("sim_pre_credits", {56'd0, credits}, 64'd1);
    next_cycle();
    din_vld = 1'b1;
    din     = 32'hF0;
    next_cycle();
    din_vld    = 1'b0;
    credit_vld = 1'b1;
    credit_cnt = 8'd1;
    next_cycle();
    credit_vld = 1'b0;
    mid();
    chk("sim_credits", {56'd0, credits}, 64'd1);
    chk("sim_pkt", {15'd0, pkt_out}, {15'd0, mk(7'd63, 32'hF0)});
    next_cycle();

    // Overflow: 1 + 125 = 126, then +5 saturates at 128 and sets the sticky flag.
    credit_vld = 1'b1;
    credit_cnt = 8'd125;
    next_cycle();
    credit_vld = 1'b0;
    mid();
    chk("ov_credits126", {56'd0, credits}, 64'd126);
    chk("ov_err_clear", {63'd0, credit_err}, 64'd0);
    next_cycle();
    credit_vld = 1'b1;
    credit_cnt = 8'd5;
    next_cycle();
    credit_vld = 1'b0;
    mid();
    chk("ov_credits_sat", {56'd0, credits}, 64'd128);
    chk("ov_err_set", {63'd0, credit_err}, 64'd1);
    next_cycle();
    mid();
    chk("ov_err_sticky", {63'd0, credit_err}, 64'd1);
    next_cycle();

    // Mid-stream reset with 8 words buffered and a stalled packet.
    do_reset();
    pkt_out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      din_vld = 1'b1;
      din     = 32'h900 + i;
      next_cycle();
    end
    din_vld = 1'b0;
    mid();
    held = pkt_out;
    chk("mr_pkt_held", {15'd0, held}, {15'd0, mk(7'd0, 32'h900)});
    chk("mr_credits", {56'd0, credits}, 64'd127);
    next_cycle();
    reset_bft = 1'b1;
    mid();
    chk("mr_ack_in_reset", {63'd0, din_ack}, 64'd0);
    next_cycle();
    reset_bft = 1'b0;
    mid();
    chk("mr_pkt_zero", {15'd0, pkt_out}, 64'd0);
    chk("mr_credits128", {56'd0, credits}, 64'd128);
    pkt_out_ready = 1'b1;
    stale = 0;
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      mid();
      if (pkt_out[48]) stale++;
      next_cycle();
    end
    chk("mr_no_stale", 64'(stale), 64'd0);
    din_vld = 1'b1;
    din     = 32'hD0;
    next_cycle();
    din_vld = 1'b0;
    next_cycle();
    mid();
    chk("mr_addr_restart", {15'd0, pkt_out}, {15'd0, mk(7'd0, 32'hD0)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/leaf_out_packetizer.md
# leaf_out_packetizer

Output-side packetizer for a BFT leaf. It accepts 32-bit words from a user kernel's output stream (ap_vld/ap_ack style) and buffers them in a small FIFO. Each word becomes a 49-bit BFT packet addressed to a configured destination leaf and port. Packets are sent only while the sender holds credits for free space in the receiver's 128-entry input buffer; credits are replenished by freespace updates from the receiver.

## Interface
Parameters:
- PACKET_BITS, 49: BFT packet width.
- PAYLOAD_BITS, 32: user word width.
- NUM_LEAF_BITS, 5: destination leaf field width.
- NUM_PORT_BITS, 4: destination port field width.
- NUM_ADDR_BITS, 7: receiver buffer address width. Initial credit count is 2^NUM_ADDR_BITS = 128.
- FIFO_DEPTH_BITS, 4: local FIFO depth is 2^FIFO_DEPTH_BITS = 16.

Ports:
- clk_bft  in  1  sole clock; all logic on the rising edge.
- reset_bft  in  1  synchronous, active-high reset.
- cfg_dest_leaf  in  5  destination leaf; sampled each time a packet is issued.
- cfg_dest_port  in  4  destination port; sampled each time a packet is issued.
- din  in  32  user data word.
- din_vld  in  1  din is valid.
- din_ack  out  1  level-sensitive ready. A transfer occurs in any cycle where din_vld && din_ack.
- pkt_out  out  49  packet: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
- pkt_out_ready  in  1  the BFT accepts pkt_out this cycle.
- credit_vld  in  1  freespace update strobe.
- credit_cnt  in  8  number of entries freed (0..128).
- credits  out  8  current credit count.
- credit_err  out  1  sticky credit overflow flag.

## Operation
- din_ack = !fifo_full && !reset_bft. It is combinational from FIFO state only; it never depends on din_vld.
- FIFO write: on din_vld && din_ack, din is pushed.
- Output stage: a single register holds pkt_out, and its bit [48] marks occupancy.
- Issue condition: fifo non-empty && credits != 0 && (!pkt_out[48] || pkt_out_ready).
- On issue:
  - Pop the FIFO.
  - Load pkt_out = {1, cfg_dest_leaf, cfg_dest_port, addr_cnt, fifo_head}.
  - Increment addr_cnt modulo 128 (127 wraps to 0).
  - Consume one credit.
- Retire without issue: when pkt_out[48] && pkt_out_ready and the issue condition is false, clear pkt_out to all-zero.
- Stall: while pkt_out[48] && !pkt_out_ready, pkt_out is held bit-for-bit stable.
- Credit update each cycle: next = credits − issue + (credit_vld ? credit_cnt : 0), computed 9 bits wide.
  - If next > 128: credits saturates to 128 and credit_err sets. credit_err clears only on reset.
  - Issue and a credit return in the same cycle both apply.
- FIFO push and pop in the same cycle are both applied. The count is unchanged; full and empty are recomputed correctly.
- With credits = 0, the FIFO keeps filling until full. din_ack then drops and no packet is issued.

## Timing
- Reset values:
  - pkt_out = 0 (all 49 bits).
  - din_ack = 0 while reset is asserted.
  - credits = 128, credit_err = 0, addr_cnt = 0, FIFO empty.
- Reset taken mid-operation discards FIFO contents and the held packet. pkt_out is 0 in the first cycle after the reset edge.
- Latency, with empty FIFO, free output stage and credits > 0: a word handshaken in cycle c appears on pkt_out with [48]=1 in cycle c+2.
- Throughput: one packet per cycle while pkt_out_ready=1, credits > 0 and input is continuous.
- A credit returned in cycle c is usable for issue in cycle c+1. An issue in cycle c is reflected in credits in cycle c+1.
- din_ack returns to 1 in the cycle after a pop from a full FIFO.

## Test plan
- Reset, then 4 words 0xA0..0xA3 back-to-back, cfg_dest_leaf=3, cfg_dest_port=2, pkt_out_ready=1:
  - 4 consecutive packets, first at cycle c+2.
  - addr 0..3, payloads in order.
  - pkt_out[47:39] = {5'd3, 4'd2}.
  - credits ends at 124.
- Backpressure: pkt_out_ready=0 for 20 cycles while pushing 20 words:
  - pkt_out stable on the first packet.
  - FIFO fills: 16 in FIFO plus 1 in the output register.
  - din_ack=0 after 17 accepted words.
  - Releasing ready drains all 17 in order with no loss or duplication.
- Credit exhaustion: send 130 words with no credit_vld:
  - exactly 128 packets issued, addr wraps 127→0 at packet 128.
  - Then credit_vld with credit_cnt=64: the remaining 2 packets issue, credits = 62.
- Simultaneous events: at credits=1, issue and credit_vld(cnt=1) in the same cycle → credits remains 1.
  - credit_vld with cnt=5 while credits=126 and no issue → credits=128, credit_err=1.
- Mid-stream reset: assert reset_bft for 1 cycle while the FIFO holds 8 words and pkt_out is stalled:
  - next cycle pkt_out=0, credits=128, addr restarts at 0.
  - no stale words emitted afterwards.
